multicycle_control: RTL

Multicycle control unit for the 16-bit RISC core. It sequences each instruction through fetch, decode, execute, memory and write-back states. It produces the 5-bit ALU function code consumed by the ALU, together with every datapath strobe and mux select. It also consumes the ALU's `takeBranch` result and the memory `mem_ready` handshake.

---
 rtl/cpu_pkg.sv | 45 ++++
 rtl/ctrl_class_decode.sv | 24 ++
 rtl/multicycle_control.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared encodings for the 16-bit RISC core: opcodes, ALU function codes,
// control FSM states, instruction classes and datapath mux selects.
package cpu_pkg;

  localparam logic [3:0] OP_R0   = 4'd0;
  localparam logic [3:0] OP_R1   = 4'd1;
  localparam logic [3:0] OP_R2   = 4'd2;
  localparam logic [3:0] OP_ADDI = 4'd3;
  localparam logic [3:0] OP_ANDI = 4'd4;
  localparam logic [3:0] OP_LW   = 4'd5;
  localparam logic [3:0] OP_LB   = 4'd6;
  localparam logic [3:0] OP_SW   = 4'd7;
  localparam logic [3:0] OP_BR0  = 4'd8;
  localparam logic [3:0] OP_BR1  = 4'd9;
  localparam logic [3:0] OP_BR2  = 4'd10;
  localparam logic [3:0] OP_BR3  = 4'd11;
  localparam logic [3:0] OP_JMP  = 4'd12;
  localparam logic [3:0] OP_CALL = 4'd13;
  localparam logic [3:0] OP_RET  = 4'd14;
  localparam logic [3:0] OP_SV   = 4'd15;

  localparam logic [4:0] ALU_ADD  = {OP_R1, 1'b0};
  localparam logic [4:0] ALU_LBS  = {OP_LB, 1'b1};
  localparam logic [4:0] ALU_LBU  = {OP_LB, 1'b0};

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB
  } state_t;

  typedef enum logic [2:0] {
    C_RTYPE, C_IMM, C_LOAD, C_STORE, C_BRANCH, C_JUMP, C_CALL, C_RET
  } op_class_t;

  typedef enum logic [1:0] {SRCB_RS2 = 2'd0, SRCB_IMM = 2'd1, SRCB_JOFF = 2'd2} srcb_t;
  typedef enum logic [1:0] {PC_PLUS2 = 2'd0, PC_BRANCH = 2'd1, PC_ALU = 2'd2} pcsrc_t;
  typedef enum logic [1:0] {WB_ALU = 2'd0, WB_MEM = 2'd1, WB_PC = 2'd2} wbsrc_t;

  // Only LB and branches pass the mode bit to the ALU; it is zero otherwise.
  function automatic logic [4:0] alu_code(input logic [3:0] op, input logic mode);
    logic m;
    m = ((op == OP_LB) || (op >= OP_BR0 && op <= OP_BR3)) ? mode : 1'b0;
    return {op, m};
  endfunction

endpackage

// File: rtl/ctrl_class_decode.sv
// Maps a 4-bit opcode to the instruction class the control FSM sequences on.
module ctrl_class_decode
  import cpu_pkg::*;
(
  input  logic [3:0] op,
  output op_class_t  cls
);

  always_comb begin
    cls = C_RTYPE;
    case (op)
      OP_R0, OP_R1, OP_R2:            cls = C_RTYPE;
      OP_ADDI, OP_ANDI:               cls = C_IMM;
      OP_LW, OP_LB:                   cls = C_LOAD;
      OP_SW, OP_SV:                   cls = C_STORE;
      OP_BR0, OP_BR1, OP_BR2, OP_BR3: cls = C_BRANCH;
      OP_JMP:                         cls = C_JUMP;
      OP_CALL:                        cls = C_CALL;
      OP_RET:                         cls = C_RET;
      default:                        cls = C_RTYPE;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle control FSM: sequences fetch/decode/execute/memory/write-back
// and drives the ALU function code, datapath strobes and mux selects.
module multicycle_control
  import cpu_pkg::*;
#(
  parameter int RETIRE_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                run,
  input  logic [15:0]         instr,
  input  logic                mem_ready,
  input  logic                take_branch,
  output logic [4:0]          alu_func,
  output logic [1:0]          alu_src_b,
  output logic                addr_src,
  output logic                mem_read,
  output logic                mem_write,
  output logic                mem_byte,
  output logic                mem_signed,
  output logic                ir_write,
  output logic                pc_write,
  output logic [1:0]          pc_src,
  output logic                reg_write,
  output logic [1:0]          wb_src,
  output logic                link_dst,
  output logic                busy,
  output logic [RETIRE_W-1:0] retired
);

  state_t    state, state_nx;
  logic [3:0] op;
  logic       mode;
  op_class_t  cls;
  logic       retire, latch;

  ctrl_class_decode u_cls (.op(op), .cls(cls));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      op      <= '0;
      mode    <= 1'b0;
      retired <= '0;
    end else begin
      state <= state_nx;
      if (latch) begin
        op   <= instr[15:12];
        mode <= instr[11];
      end
      if (retire) retired <= retired + 1'b1;
    end
  end

  always_comb begin
    state_nx   = state;
    latch      = 1'b0;
    retire     = 1'b0;
    alu_func   = '0;
    alu_src_b  = SRCB_RS2;
    addr_src   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_byte   = 1'b0;
    mem_signed = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = PC_PLUS2;
    reg_write  = 1'b0;
    wb_src     = WB_ALU;
    link_dst   = 1'b0;
    busy       = (state != S_IDLE);
    // The function code stays on the ALU from decode until the instruction ends.
    if (state inside {S_DECODE, S_EXEC, S_MEM, S_WB}) alu_func = alu_code(op, mode);

    case (state)
      S_IDLE: if (run) state_nx = S_FETCH;
      S_FETCH: begin
        mem_read = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          latch    = 1'b1;
          state_nx = S_DECODE;
        end
      end
      S_DECODE: state_nx = S_EXEC;
      S_EXEC: begin
        case (cls)
          C_RTYPE: state_nx = S_WB;
          C_IMM: begin
            alu_src_b = SRCB_IMM;
            state_nx  = S_WB;
          end
          C_LOAD: begin
            alu_src_b = SRCB_IMM;
            state_nx  = S_MEM;
          end
          C_STORE: begin
            // Sv addresses through the ALU without an immediate offset.
            alu_src_b = (op == OP_SW) ? SRCB_IMM : SRCB_RS2;
            state_nx  = S_MEM;
          end
          C_BRANCH: begin
            pc_write = take_branch;
            pc_src   = PC_BRANCH;
            retire   = 1'b1;
            state_nx = S_FETCH;
          end
          C_JUMP, C_CALL: begin
            alu_src_b = SRCB_JOFF;
            pc_write  = 1'b1;
            pc_src    = PC_ALU;
            reg_write = (cls == C_CALL);
            wb_src    = (cls == C_CALL) ? WB_PC : WB_ALU;
            link_dst  = (cls == C_CALL);
            retire    = 1'b1;
            state_nx  = S_FETCH;
          end
          C_RET: begin
            pc_write = 1'b1;
            pc_src   = PC_ALU;
            retire   = 1'b1;
            state_nx = S_FETCH;
          end
          default: state_nx = S_FETCH;
        endcase
      end
      S_MEM: begin
        addr_src = 1'b1;
        if (cls == C_LOAD) begin
          mem_read   = 1'b1;
          mem_byte   = (op == OP_LB);
          mem_signed = (op == OP_LB) && mode;
        end else begin
          mem_write = 1'b1;
        end
        if (mem_ready) begin
          if (cls == C_LOAD) begin
            state_nx = S_WB;
          end else begin
            retire   = 1'b1;
            state_nx = S_FETCH;
          end
        end
      end
      S_WB: begin
        reg_write = 1'b1;
        wb_src    = (cls == C_LOAD) ? WB_MEM : WB_ALU;
        retire    = 1'b1;
        state_nx  = S_FETCH;
      end
      default: state_nx = S_IDLE;
    endcase
  end

endmodule
